gpi_conditioner: RTL and testbench
==================================

Name: gpi_conditioner

Overview:
Input-conditioning stage directly upstream of the Eighty_Twos core's gpi bus. It takes raw breakout-board pins and delivers them to the core in a clean, clock-aligned form:
- every pin passes through a 2-flop synchroniser;
- button pins are debounced and produce one-cycle press pulses;
- the strobe pin is edge-detected;
- the shared 8-bit data bus is held while the core is driving it (store_en).

Parameters:
GPIO_W, 34, total pin count (width of gpio_in/gpi)
DB_CYCLES, 16, consecutive stable cycles required to accept a button level change (>=2)
SYNC_STAGES, 2, synchroniser depth (>=2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
ncs  input  1  chip select, active-low; high = block frozen
gpio_in  input  GPIO_W  raw breakout-board pins
store_en  input  1  from core; high = core drives data pins [7:0] as outputs
gpi  output  GPIO_W  conditioned pins to core
btn_pulse  output  8  one-cycle pulse per debounced rising edge of pins [15:8]
strobe_pulse  output  1  one-cycle pulse on synchronised rising edge of pin 16

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst); all registers update on rising clk.
- Reset values: all synchroniser flops, gpi, btn_pulse, strobe_pulse, debounce counters and stable levels = 0.
- Synchroniser: SYNC_STAGES-deep flop chain on all GPIO_W pins (sync_q). It runs regardless of ncs.
- gpi is registered. When ncs=1, gpi holds its value and btn_pulse/strobe_pulse are forced to 0.
- Debounce counters and stable levels freeze while ncs=1. They resume from their held value when ncs returns to 0.
- Data pins [7:0]:
  - store_en=0: gpi[7:0] <= sync_q[7:0].
  - store_en=1: gpi[7:0] holds, so the core's own driven value is never sampled back.
  - Latency from pin change to gpi = SYNC_STAGES+1 cycles.
- Button pins [15:8], per pin, with counter cnt (width $clog2(DB_CYCLES)) and stable level stb:
  - sync_q==stb: cnt<=0.
  - sync_q!=stb and cnt<DB_CYCLES-1: cnt<=cnt+1.
  - sync_q!=stb and cnt==DB_CYCLES-1: stb<=sync_q and cnt<=0.
  - gpi[15:8] = stb, registered.
  - btn_pulse[i]=1 for exactly the cycle after stb[i] goes 0->1. No pulse on 1->0.
  - A glitch shorter than DB_CYCLES resets cnt and stb does not change.
- Strobe pin 16:
  - gpi[16] = sync_q[16].
  - strobe_pulse=1 for one cycle when sync_q[16]=1 and its previous value was 0.
  - Pin held high produces a single pulse.
- Pins [GPIO_W-1:17]: gpi <= sync_q, pass-through.
- Simultaneous events:
  - store_en rising in the same cycle as a data change: the hold wins, and gpi keeps the pre-edge value.
  - rst wins over everything, including mid-debounce: cnt cleared, stb=0, no pulse.

Optional Feature:
Macro GPI_GLITCH_COUNT_EN.
- Defined: adds output glitch_cnt [7:0], an 8-bit counter.
  - Increments when any button pin aborts a debounce, i.e. sync_q returns equal to stb while cnt!=0.
  - Saturates at 255; multiple pins aborting in the same cycle count once.
  - Reset to 0; frozen while ncs=1.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package gpi_cond_pkg holds the pin-map constants: DATA_LSB=0, DATA_MSB=7, BTN_LSB=8, BTN_MSB=15, STROBE_IDX=16, GPIO_W_DEF=34.
- Sub-module gpi_debounce: one-bit counter/stable-level/rising-pulse cell, parameterised by DB_CYCLES, with ports clk, rst, en (=~ncs), d, q, rise, abort. Instantiated 8 times via generate.

Test Plan:
- Reset: rst=1 for 2 cycles with gpio_in='1 -> gpi=0, btn_pulse=0, strobe_pulse=0. After release, gpi[7:0]=8'hFF on the 3rd cycle.
- Data hold: gpio_in[7:0]=8'hA5, wait 4 cycles, set store_en=1, drive 8'h3C -> gpi[7:0] stays 8'hA5. After store_en=0, gpi[7:0]=8'h3C within 3 cycles.
- Debounce accept: gpio_in[8] 0->1 held 20 cycles, DB_CYCLES=16 -> gpi[8] rises at cycle 2+16+1. btn_pulse[0] high exactly 1 cycle.
- Glitch reject: gpio_in[9] high for 10 cycles then low -> gpi[9] stays 0, btn_pulse=0. With the macro, glitch_cnt=1.
- Strobe: gpio_in[16] high for 50 cycles -> exactly one strobe_pulse, 3 cycles after the edge.
- Chip select: ncs=1 while gpio_in[20] toggles and gpio_in[10] is pressed -> gpi unchanged, no pulses. After ncs=0, gpi[20] tracks the pin and the button debounce completes.

Source files
------------

// File: rtl/gpi_cond_pkg.sv
// Pin map shared by the gpi input-conditioning block and its bench.
package gpi_cond_pkg;

    localparam int DATA_LSB   = 0;
    localparam int DATA_MSB   = 7;
    localparam int BTN_LSB    = 8;
    localparam int BTN_MSB    = 15;
    localparam int BTN_N      = BTN_MSB - BTN_LSB + 1;
    localparam int STROBE_IDX = 16;
    localparam int GPIO_W_DEF = 34;

endpackage

// File: rtl/gpi_debounce.sv
// One button cell: accepts a level change after DB_CYCLES stable cycles,
// flags the accepted 0->1 transition and any aborted debounce attempt.
module gpi_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q,
    output logic rise,
    output logic abort
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            q    <= 1'b0;
            rise <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (en) begin
                if (d == q) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    q    <= d;
                    cnt  <= '0;
                    rise <= d;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign abort = en && (d == q) && (cnt != '0);

endmodule

// File: rtl/gpi_conditioner.sv
// Conditions raw breakout pins for the core's gpi bus: synchroniser, data hold,
// button debounce and strobe edge detect. Optional macro: GPI_GLITCH_COUNT_EN.
module gpi_conditioner
    import gpi_cond_pkg::*;
#(
    parameter int GPIO_W      = GPIO_W_DEF,
    parameter int DB_CYCLES   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ncs,
    input  logic [GPIO_W-1:0] gpio_in,
    input  logic              store_en,
    output logic [GPIO_W-1:0] gpi,
    output logic [BTN_N-1:0]  btn_pulse,
    output logic              strobe_pulse
`ifdef GPI_GLITCH_COUNT_EN
    ,
    output logic [7:0]        glitch_cnt
`endif
);

    logic [GPIO_W-1:0] sync_p [SYNC_STAGES];
    logic [GPIO_W-1:0] sync_q;
    logic [BTN_N-1:0]  stb;
    logic [BTN_N-1:0]  rise;
    logic [BTN_N-1:0]  abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
        end else begin
            sync_p[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
        end
    end

    assign sync_q = sync_p[SYNC_STAGES-1];

    for (genvar i = 0; i < BTN_N; i++) begin : g_btn
        gpi_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .en    (~ncs),
            .d     (sync_q[BTN_LSB+i]),
            .q     (stb[i]),
            .rise  (rise[i]),
            .abort (abort[i])
        );
    end

    // Output stage; the previous gpi[STROBE_IDX] doubles as the strobe edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpi          <= '0;
            btn_pulse    <= '0;
            strobe_pulse <= 1'b0;
        end else if (ncs) begin
            btn_pulse    <= '0;
            strobe_pulse <= 1'b0;
        end else begin
            if (!store_en) gpi[DATA_MSB:DATA_LSB] <= sync_q[DATA_MSB:DATA_LSB];
            gpi[BTN_MSB:BTN_LSB]     <= stb;
            gpi[GPIO_W-1:STROBE_IDX] <= sync_q[GPIO_W-1:STROBE_IDX];
            btn_pulse                <= rise;
            strobe_pulse             <= sync_q[STROBE_IDX] & ~gpi[STROBE_IDX];
        end
    end

`ifdef GPI_GLITCH_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_cnt <= '0;
        end else if (!ncs && (|abort) && (glitch_cnt != 8'hFF)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
`else
    logic unused_abort;
    assign unused_abort = ^abort;
`endif

endmodule

// File: tb/tb_gpi_conditioner.sv
// Directed bench for gpi_conditioner; also checks glitch_cnt when GPI_GLITCH_COUNT_EN is set.
module tb_gpi_conditioner;

    localparam int GPIO_W = 34;

    logic              clk = 1'b0;
    logic              rst;
    logic              ncs;
    logic [GPIO_W-1:0] gpio_in;
    logic              store_en;
    logic [GPIO_W-1:0] gpi;
    logic [7:0]        btn_pulse;
    logic              strobe_pulse;
`ifdef GPI_GLITCH_COUNT_EN
    logic [7:0]        glitch_cnt;
    logic [7:0]        glitch_base;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int btn_seen = 0;
    int stb_seen = 0;
    int base;

    gpi_conditioner #(.GPIO_W(GPIO_W), .DB_CYCLES(16), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .ncs          (ncs),
        .gpio_in      (gpio_in),
        .store_en     (store_en),
        .gpi          (gpi),
        .btn_pulse    (btn_pulse),
        .strobe_pulse (strobe_pulse)
`ifdef GPI_GLITCH_COUNT_EN
        ,
        .glitch_cnt   (glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        btn_seen += $countones(btn_pulse);
        stb_seen += int'(strobe_pulse);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ncs = 1'b0; store_en = 1'b0; gpio_in = '1;
        step(2);
        check("rst_gpi", gpi, 0);
        check("rst_btn", btn_pulse, 0);
        check("rst_strobe", strobe_pulse, 0);
        rst = 1'b0;
        step(2);
        check("rel_cycle2_data", gpi[7:0], 8'h00);
        step(1);
        check("rel_cycle3_data", gpi[7:0], 8'hFF);
        check("rel_cycle3_pin16", gpi[16], 1'b1);
        check("rel_cycle3_strobe", strobe_pulse, 1'b1);
        gpio_in = '0;
        step(25);
        check("settle_gpi", gpi, 0);

        // Data hold: store_en rises together with the data change.
        gpio_in[7:0] = 8'hA5;
        step(4);
        check("data_a5", gpi[7:0], 8'hA5);
        store_en = 1'b1; gpio_in[7:0] = 8'h3C;
        step(1);
        check("hold_edge", gpi[7:0], 8'hA5);
        step(5);
        check("hold_long", gpi[7:0], 8'hA5);
        store_en = 1'b0;
        step(1);
        check("release_3c", gpi[7:0], 8'h3C);

`ifdef GPI_GLITCH_COUNT_EN
        glitch_base = glitch_cnt;
`endif
        // Debounce accept on pin 8.
        base = btn_seen;
        gpio_in[8] = 1'b1;
        step(18);
        check("db_pre_gpi8", gpi[8], 1'b0);
        check("db_pre_pulse", btn_pulse, 8'h00);
        step(1);
        check("db_gpi8", gpi[8], 1'b1);
        check("db_pulse", btn_pulse, 8'h01);
        step(1);
        check("db_pulse_end", btn_pulse, 8'h00);
        gpio_in[8] = 1'b0;
        step(25);
        check("db_release_gpi8", gpi[8], 1'b0);
        check("db_pulse_count", btn_seen - base, 1);

        // Glitch reject on pin 9.
        base = btn_seen;
        gpio_in[9] = 1'b1;
        step(10);
        gpio_in[9] = 1'b0;
        step(30);
        check("glitch_gpi9", gpi[9], 1'b0);
        check("glitch_pulses", btn_seen - base, 0);
`ifdef GPI_GLITCH_COUNT_EN
        check("glitch_cnt_inc", glitch_cnt - glitch_base, 8'd1);
`endif

        // Strobe on pin 16 held high.
        base = stb_seen;
        gpio_in[16] = 1'b1;
        step(2);
        check("strobe_early", strobe_pulse, 1'b0);
        step(1);
        check("strobe_edge", strobe_pulse, 1'b1);
        step(47);
        check("strobe_count", stb_seen - base, 1);
        gpio_in[16] = 1'b0;
        step(5);

        // Chip select frozen while pins move.
        base = btn_seen + stb_seen;
        ncs = 1'b1;
        gpio_in[10] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            gpio_in[20] = ~gpio_in[20];
            step(1);
        end
        gpio_in[20] = 1'b1;
        step(2);
        check("ncs_gpi_frozen", gpi, 34'h0_0000_003C);
        check("ncs_no_pulses", btn_seen + stb_seen - base, 0);
        ncs = 1'b0;
        step(1);
        check("ncs_pin20", gpi[20], 1'b1);
        step(15);
        check("ncs_db_pending", gpi[10], 1'b0);
        step(1);
        check("ncs_db_done", gpi[10], 1'b1);
        check("ncs_db_pulse", btn_pulse, 8'h04);

        // Reset during a debounce in progress.
        gpio_in[11] = 1'b1;
        step(8);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_mid_gpi", gpi, 0);
        check("rst_mid_pulse", btn_pulse, 8'h00);
        step(1);
        check("rst_mid_gpi11", gpi[11], 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
